// File: rtl/polyphase_pkg.sv
// Shared types for the polyphase FIR output path: sample, phase index, frame and
// the serializer FSM state encoding.
package polyphase_pkg;

  localparam int NPHASE = 4;
  localparam int DW     = 8;
  localparam int PHW    = $clog2(NPHASE);

  typedef logic signed [DW-1:0] sample_t;   // sfix8_En7
  typedef logic [PHW-1:0]       phase_idx_t;
  typedef sample_t              frame_t [NPHASE];

  typedef enum logic [1:0] {
    S_EMPTY,
    S_STREAM,
    S_LAST
  } ser_state_t;

  localparam phase_idx_t LAST_PHASE = phase_idx_t'(NPHASE - 1);

endpackage

// File: rtl/frame_fifo.sv
// FRAME_DEPTH-entry frame buffer with wrapping pointers, occupancy count and
// full/empty flags. FRAME_DEPTH must be a power of two so pointers wrap naturally.
module frame_fifo
  import polyphase_pkg::*;
#(
  parameter int FRAME_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         wr,
  input  logic                         rd,
  input  frame_t                       wr_data,
  output frame_t                       rd_data,
  output logic [$clog2(FRAME_DEPTH):0] count,
  output logic                         full,
  output logic                         empty
);

  localparam int PW = $clog2(FRAME_DEPTH);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  frame_t mem_q [FRAME_DEPTH];
  ptr_t   wr_ptr_q, rd_ptr_q;
  cnt_t   count_q;

  // NOTE: storage has no reset; emptiness is tracked by count_q alone, which
  // keeps the array out of the reset tree and lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (en && wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (en) begin
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr, rd})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == cnt_t'(FRAME_DEPTH));
  assign empty   = (count_q == '0);

endmodule

// File: rtl/polyphase_out_serializer.sv
// Buffers parallel polyphase frames and streams them phase 0 first over valid/ready.
// Define SER_DROP_CNT_EN to add a saturating 16-bit drop_count output.
module polyphase_out_serializer
  import polyphase_pkg::*;
#(
  parameter int FRAME_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_enable,
  input  logic [NPHASE*DW-1:0] frame_in,
  input  logic                 frame_valid,
  output logic signed [DW-1:0] sample_out,
  output logic [PHW-1:0]       sample_phase,
  output logic                 sample_last,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 frame_drop,
  output logic                 busy
`ifdef SER_DROP_CNT_EN
  ,
  output logic [15:0]          drop_count
`endif
);

  localparam int CW = $clog2(FRAME_DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;

  frame_t     in_frame, rd_frame;
  cnt_t       fifo_count;
  logic       fifo_full, fifo_empty;
  logic       xfer, pop, push, drop;
  ser_state_t state_q;
  phase_idx_t phase_q, phase_inc;
  logic       frame_drop_q;

  // NOTE: every output of this block is assigned on every pass, so no latch.
  always_comb begin
    for (int k = 0; k < NPHASE; k++) in_frame[k] = frame_in[k*DW +: DW];
  end

  // A pop frees a slot in the same edge, so a full buffer can still accept.
  assign sample_valid = clk_enable && !fifo_empty;
  assign xfer         = sample_valid && sample_ready;
  assign pop          = xfer && (phase_q == LAST_PHASE);
  assign push         = clk_enable && frame_valid && (!fifo_full || pop);
  assign drop         = clk_enable && frame_valid && fifo_full && !pop;
  assign phase_inc    = phase_q + 1'b1;

  frame_fifo #(.FRAME_DEPTH(FRAME_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .en      (clk_enable),
    .wr      (push),
    .rd      (pop),
    .wr_data (in_frame),
    .rd_data (rd_frame),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_EMPTY;
      phase_q      <= '0;
      frame_drop_q <= 1'b0;
    end else if (clk_enable) begin
      frame_drop_q <= drop;
      case (state_q)
        S_EMPTY:  if (push) state_q <= S_STREAM;
        S_STREAM: if (xfer) begin
          phase_q <= phase_inc;
          if (phase_inc == LAST_PHASE) state_q <= S_LAST;
        end
        S_LAST:   if (xfer) begin
          phase_q <= '0;
          state_q <= (fifo_count > cnt_t'(1) || push) ? S_STREAM : S_EMPTY;
        end
        default:  state_q <= S_EMPTY;
      endcase
    end
  end

  assign sample_out   = fifo_empty ? '0 : rd_frame[phase_q];
  assign sample_phase = phase_q;
  assign sample_last  = (state_q == S_LAST);
  assign frame_drop   = frame_drop_q;
  assign busy         = !fifo_empty;

`ifdef SER_DROP_CNT_EN
  logic [15:0] drop_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             drop_count_q <= '0;
    else if (drop && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
  end

  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_polyphase_out_serializer.sv
// Self-checking bench: directed scenarios then random traffic against a frame-queue
// reference model of the serializer.
module tb_polyphase_out_serializer;

  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_enable;
  logic [31:0]        frame_in;
  logic               frame_valid;
  logic signed [7:0]  sample_out;
  logic [1:0]         sample_phase;
  logic               sample_last;
  logic               sample_valid;
  logic               sample_ready;
  logic               frame_drop;
  logic               busy;
`ifdef SER_DROP_CNT_EN
  logic [15:0]        drop_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: accepted frames in arrival order, head removed after its last sample.
  logic [31:0] mq[$];
  int          m_ph   = 0;
  logic        m_drop = 1'b0;
  int          m_dcnt = 0;

  polyphase_out_serializer #(.FRAME_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .frame_in     (frame_in),
    .frame_valid  (frame_valid),
    .sample_out   (sample_out),
    .sample_phase (sample_phase),
    .sample_last  (sample_last),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_drop   (frame_drop),
    .busy         (busy)
`ifdef SER_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic en);
    logic        ne;
    logic [31:0] head;
    ne   = (mq.size() > 0);
    head = ne ? mq[0] : 32'h0;
    check("sample_valid", {31'h0, sample_valid}, {31'h0, en && ne});
    check("busy",         {31'h0, busy},         {31'h0, ne});
    check("sample_out",   {24'h0, sample_out},   ne ? ((head >> (8 * m_ph)) & 32'hFF) : 32'h0);
    check("sample_phase", {30'h0, sample_phase}, 32'(m_ph));
    check("sample_last",  {31'h0, sample_last},  {31'h0, ne && m_ph == 3});
    check("frame_drop",   {31'h0, frame_drop},   {31'h0, m_drop});
`ifdef SER_DROP_CNT_EN
    check("drop_count",   {16'h0, drop_count},   32'(m_dcnt));
`endif
  endtask

  // Drive one cycle's inputs just after a falling edge, check, then advance the model.
  task automatic cycle(input logic en, input logic fv, input logic [31:0] fd, input logic rdy);
    logic ne, xfer, pop, acc;
    clk_enable   = en;
    frame_valid  = fv;
    frame_in     = fd;
    sample_ready = rdy;
    #1;
    check_outputs(en);
    if (en) begin
      ne     = (mq.size() > 0);
      xfer   = ne && rdy;
      pop    = xfer && (m_ph == 3);
      acc    = fv && ((mq.size() < DEPTH) || pop);
      m_drop = fv && !acc;
      if (m_drop && m_dcnt < 65535) m_dcnt++;
      if (pop) begin
        void'(mq.pop_front());
        m_ph = 0;
      end else if (xfer) begin
        m_ph++;
      end
      if (acc) mq.push_back(fd);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, rdy);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ph   = 0;
    m_drop = 1'b0;
    m_dcnt = 0;
  endtask

  initial begin
    reset        = 1'b0;
    clk_enable   = 1'b0;
    frame_valid  = 1'b0;
    frame_in     = '0;
    sample_ready = 1'b0;
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single frame, ready high.
    cycle(1'b1, 1'b1, 32'h4030_2010, 1'b1);
    idle(6, 1'b1);

    // Two back-to-back frames; 0x81 is -127 and must pass unchanged.
    cycle(1'b1, 1'b1, 32'h0403_0201, 1'b1);
    cycle(1'b1, 1'b1, 32'h8483_8281, 1'b1);
    idle(9, 1'b1);

    // Three frames with ready low: third is dropped, then drain.
    cycle(1'b1, 1'b1, 32'h1312_1110, 1'b0);
    cycle(1'b1, 1'b1, 32'h2322_2120, 1'b0);
    cycle(1'b1, 1'b1, 32'h3332_3130, 1'b0);
    idle(3, 1'b0);
    idle(10, 1'b1);

    // Ready toggling 1,0,0,1 mid-frame.
    cycle(1'b1, 1'b1, 32'hA4A3_A2A1, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    idle(5, 1'b1);

    // Asynchronous reset while the frame sits at phase 2.
    cycle(1'b1, 1'b1, 32'h5453_5251, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    check("phase_before_reset", {30'h0, sample_phase}, 32'd2);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs(1'b1);
    @(negedge clk);
    reset = 1'b1;
    idle(1, 1'b1);
    cycle(1'b1, 1'b1, 32'h6463_6261, 1'b1);
    idle(5, 1'b1);

    // clk_enable low for three cycles with a strobe while a frame is pending.
    cycle(1'b1, 1'b1, 32'h7473_7271, 1'b1);
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'hCAFE_F00D, 1'b1);
    idle(6, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
            $urandom, ($urandom_range(0, 9) < 6));
    end
    idle(12, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/polyphase_out_serializer.md
Name: polyphase_out_serializer

Overview:
- Consumes the four parallel sfix8_En7 phase outputs produced each input-sample period by the cascaded polyphase FIR bank (fir1..fir4 outputs, phase 0..3).
- Buffers whole frames and emits them as a serial sample stream, phase 0 first, over a valid/ready handshake.
- Sits between the FIR bank and any downstream serial consumer (DAC interface, capture logic); it is the reading end of the bank's parallel output.

Parameters:
- NPHASE, 4, phases per frame (number of FIR branches).
- DW, 8, sample width (sfix8_En7).
- FRAME_DEPTH, 2, frames held in the internal buffer (power of two, >=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clk_enable  input  1  global enable; low freezes all state.
- frame_in  input  NPHASE*DW  packed phase samples; phase k in bits [k*DW +: DW].
- frame_valid  input  1  one-cycle strobe: frame_in holds a new frame.
- sample_out  output  DW  current serial sample (signed).
- sample_phase  output  clog2(NPHASE)  phase index of sample_out.
- sample_last  output  1  high with the final phase (NPHASE-1) of a frame.
- sample_valid  output  1  sample_out is valid.
- sample_ready  input  1  downstream accepts sample when high with sample_valid.
- frame_drop  output  1  one-cycle pulse: an incoming frame was discarded.
- busy  output  1  buffer holds at least one frame.

Behaviour:
- Reset (reset low, asynchronous): buffer empty, phase counter 0, wr/rd pointers 0. Outputs: sample_valid 0, sample_out 0, sample_phase 0, sample_last 0, frame_drop 0, busy 0. Frames held when reset asserts mid-stream are discarded.
- clk_enable low: no register updates. sample_valid is forced to 0, so no transfer can occur. frame_valid is ignored.
- Write (clk_enable and frame_valid): if not full, the frame goes to wr_ptr, wr_ptr increments mod FRAME_DEPTH, and count increments.
- Drop: if the buffer is full and no pop occurs in the same cycle, the frame is discarded and frame_drop pulses in the following cycle. Full with a simultaneous pop: the write is accepted and count is unchanged.
- Latency: a frame captured at edge N is offered (sample_valid=1, phase 0) in the cycle after edge N. With sample_ready held high, NPHASE consecutive samples follow with no bubbles.
- Read path: sample_out = buffer[rd_ptr] phase[phase_cnt]. This is a combinational mux from registered storage; sample_out is 0 when the buffer is empty.
- Transfer (sample_valid and sample_ready): phase_cnt increments. When phase_cnt == NPHASE-1: phase_cnt goes to 0, rd_ptr increments, count decrements, and the next frame (if any) starts in the next cycle without a gap.
- Stall: sample_valid high and sample_ready low hold sample_out, sample_phase and sample_last stable.
- FSM states:
  - EMPTY (count 0): to STREAM on write.
  - STREAM (count>0, phase<NPHASE-1): to LAST when phase reaches NPHASE-1.
  - LAST: to STREAM on transfer if count after pop >0 or a write is simultaneous; otherwise to EMPTY.
- Simultaneous write to an empty buffer and read: impossible (sample_valid is 0 when empty). The written frame is offered next cycle.
- Arithmetic: data passes unmodified; no rounding or sign extension. Pointers wrap mod FRAME_DEPTH. count width is clog2(FRAME_DEPTH)+1.

Optional Feature:
- Macro: SER_DROP_CNT_EN.
- Defined: adds output drop_count [15:0]. It increments on every frame_drop pulse, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and counter do not exist. frame_drop behaviour is identical in both builds.

Decomposition:
- Shared package polyphase_pkg:
  - NPHASE and DW constants.
  - typedef sample_t (logic signed [DW-1:0], sfix8_En7).
  - typedef phase_idx_t.
  - typedef frame_t (sample_t array [NPHASE]).
  - FSM state enum ser_state_t.
- One sub-module, frame_fifo: FRAME_DEPTH x frame_t storage with pointers, count, full and empty. The serializer top holds the FSM, phase counter and handshake.

Test Plan:
- Single frame 0x10,0x20,0x30,0x40, sample_ready=1 -> outputs 0x10..0x40 on consecutive cycles starting the cycle after capture; phases 0..3; sample_last only with 0x40; busy returns to 0.
- Two back-to-back frames (A: 01..04, B: 81..84), ready=1 -> 8 samples with no bubble; 0x81 is signed -127 and passes unchanged.
- Three frames in consecutive cycles, ready=0 -> frames 1 and 2 buffered, frame 3 dropped, frame_drop pulses once. With SER_DROP_CNT_EN, drop_count=1. Releasing ready emits frames 1 and 2 only.
- Ready toggling 1,0,0,1 mid-frame -> sample_out and sample_phase held during stall; no sample duplicated or skipped.
- Assert reset low mid-frame at phase 2 -> all outputs 0 immediately (asynchronous); after release, busy=0 and the next frame starts at phase 0.
- clk_enable low for 3 cycles with frame_valid pulsed and a frame pending -> sample_valid 0, strobe ignored, state preserved; streaming resumes at the same phase.
